// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle control sequencer for the 8-bit datapath.
// Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB.
// The sequencer waits for the instruction and data memories to report ready.
// It counts retired instructions.
// It traps into FAULT on an undefined opcode or when a memory wait runs too long.
module sequenciador_multiciclo #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       alu_zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic       alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    // Opcode classes: the top two bits select the group.
    // Inside group 11 the low two bits select load/store/jump/halt.
    function automatic logic op_is_beq(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

    function automatic logic op_is_undef(input logic [3:0] op);
        return (op[3:2] == 2'b01);
    endfunction

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == 4'b1100);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == 4'b1101);
    endfunction

    function automatic logic op_is_jump(input logic [3:0] op);
        return (op == 4'b1110);
    endfunction

    function automatic logic op_is_halt(input logic [3:0] op);
        return (op == 4'b1111);
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] op_reg_r;
    logic [7:0] wait_cnt_r;
    logic [7:0] retired_r;
    logic       halted_r;
    logic       fault_r;
    logic       retire_s;
    logic       wait_expired_s;
    logic       unused_instr_bits_s;

    // The low opcode bits feed the datapath immediate, not the sequencer.
    assign unused_instr_bits_s = ^instr[3:0];

    assign wait_expired_s = (wait_cnt_r == WAIT_LIMIT);

    // Next-state and control decode; ready beats timeout on the same cycle.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_NEXT;
        alu_src      = 1'b0;
        alu_op       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    next_state_s = ST_DECODE;
                end else if (wait_expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end

            // The instruction register is decoded directly here.
            // Later states use only the latched op_reg.
            ST_DECODE: begin
                if (op_is_halt(instr[7:4])) begin
                    next_state_s = ST_HALT;
                end else if (op_is_jump(instr[7:4])) begin
                    pc_write     = 1'b1;
                    pc_src       = PC_JUMP;
                    retire_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else if (op_is_undef(instr[7:4])) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (op_is_beq(op_reg_r)) begin
                    alu_op       = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = alu_zero ? PC_BRANCH : PC_NEXT;
                    retire_s     = 1'b1;
                    next_state_s = ST_FETCH;
                end else if (op_is_alu(op_reg_r)) begin
                    alu_src      = 1'b1;
                    alu_op       = 1'b1;
                    next_state_s = ST_WB;
                end else if (op_is_load(op_reg_r) || op_is_store(op_reg_r)) begin
                    alu_src      = 1'b1;
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end

            ST_MEM: begin
                if (op_is_load(op_reg_r)) begin
                    mem_read = 1'b1;
                end else begin
                    mem_write = op_is_store(op_reg_r);
                end
                if (dmem_ready) begin
                    if (op_is_load(op_reg_r)) begin
                        next_state_s = ST_WB;
                    end else if (op_is_store(op_reg_r)) begin
                        pc_write     = 1'b1;
                        pc_src       = PC_NEXT;
                        retire_s     = 1'b1;
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_FAULT;
                    end
                end else if (wait_expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_MEM;
                end
            end

            ST_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = op_is_load(op_reg_r);
                pc_write     = 1'b1;
                pc_src       = PC_NEXT;
                retire_s     = 1'b1;
                next_state_s = ST_FETCH;
            end

            ST_HALT: begin
                next_state_s = ST_HALT;
            end

            ST_FAULT: begin
                next_state_s = ST_FAULT;
            end

            default: begin
                next_state_s = ST_FAULT;
            end
        endcase
    end

    // State register plus registered HALT/FAULT status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= (next_state_s == ST_HALT);
            fault_r  <= (next_state_s == ST_FAULT);
        end
    end

    // Latch the opcode while in DECODE so EXEC/MEM/WB are immune to IR changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_reg_r <= 4'd0;
        end else if (state_r == ST_DECODE) begin
            op_reg_r <= instr[7:4];
        end else begin
            op_reg_r <= op_reg_r;
        end
    end

    // Memory wait counter: restarts on every state change.
    // It counts stalled FETCH/MEM cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_r <= 8'd0;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Retired-instruction counter; wraps naturally from 255 to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_r <= 8'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 8'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign state   = state_r;
    assign halted  = halted_r;
    assign fault   = fault_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Table-driven bench for sequenciador_multiciclo (instantiated with WAIT_MAX=3).
// Each row gives one cycle of inputs and the outputs expected during that cycle.
module tb_sequenciador_multiciclo;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] instr;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic       alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
    logic       fault;
    logic [2:0] state;
    logic [7:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    sequenciador_multiciclo #(.WAIT_MAX(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .halted     (halted),
        .fault      (fault),
        .state      (state),
        .retired    (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control vector order:
    // imem_req ir_write pc_write pc_src[1:0] alu_src alu_op reg_write
    // mem_to_reg mem_read mem_write halted fault
    localparam logic [12:0] C_NONE   = 13'b0_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_FWAIT  = 13'b1_0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_FRDY   = 13'b1_1_0_00_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_EX_ALU = 13'b0_0_0_00_1_1_0_0_0_0_0_0;
    localparam logic [12:0] C_WB_ALU = 13'b0_0_1_00_0_0_1_0_0_0_0_0;
    localparam logic [12:0] C_BEQ_T  = 13'b0_0_1_01_0_1_0_0_0_0_0_0;
    localparam logic [12:0] C_BEQ_N  = 13'b0_0_1_00_0_1_0_0_0_0_0_0;
    localparam logic [12:0] C_EX_MEM = 13'b0_0_0_00_1_0_0_0_0_0_0_0;
    localparam logic [12:0] C_MRD    = 13'b0_0_0_00_0_0_0_0_1_0_0_0;
    localparam logic [12:0] C_WB_LD  = 13'b0_0_1_00_0_0_1_1_0_0_0_0;
    localparam logic [12:0] C_ST_RDY = 13'b0_0_1_00_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_MWR    = 13'b0_0_0_00_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_JMP    = 13'b0_0_1_10_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_HALT   = 13'b0_0_0_00_0_0_0_0_0_0_1_0;
    localparam logic [12:0] C_FAULT  = 13'b0_0_0_00_0_0_0_0_0_0_0_1;

    typedef struct {
        logic        rst;
        logic        st;
        logic [7:0]  ins;
        logic        az;
        logic        ir;
        logic        dr;
        logic [2:0]  exp_state;
        logic [12:0] exp_ctl;
        logic [7:0]  exp_ret;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic [7:0] ins,
                                input logic az, input logic ir, input logic dr,
                                input logic [2:0] es, input logic [12:0] ec,
                                input logic [7:0] er);
        vec_t v;
        v.rst = rst; v.st = st; v.ins = ins; v.az = az; v.ir = ir; v.dr = dr;
        v.exp_state = es; v.exp_ctl = ec; v.exp_ret = er;
        return v;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    logic [12:0] ctl_s;
    assign ctl_s = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, reg_write,
                    mem_to_reg, mem_read, mem_write, halted, fault};

    initial begin
        // rst st instr az ir dr | state ctl retired
        // ALU op, zero-wait fetch
        vecs.push_back(mk(1'b1, 1'b0, 8'h98, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h98, 1'b0, 1'b1, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h98, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h98, 1'b0, 1'b1, 1'b0, 3'd2, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h98, 1'b0, 1'b1, 1'b0, 3'd3, C_EX_ALU, 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h98, 1'b0, 1'b1, 1'b0, 3'd5, C_WB_ALU, 8'd0));
        // beq taken, then not taken with IR changed during EXEC
        vecs.push_back(mk(1'b0, 1'b0, 8'h28, 1'b1, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h28, 1'b1, 1'b1, 1'b0, 3'd2, C_NONE,   8'd1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h28, 1'b1, 1'b1, 1'b0, 3'd3, C_BEQ_T,  8'd1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h28, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd2));
        vecs.push_back(mk(1'b0, 1'b0, 8'h28, 1'b0, 1'b1, 1'b0, 3'd2, C_NONE,   8'd2));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 3'd3, C_BEQ_N,  8'd2));
        // load, dmem ready on the WAIT_MAX cycle (ready beats timeout)
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 3'd2, C_NONE,   8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 3'd3, C_EX_MEM, 8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd4, C_MRD,    8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd4, C_MRD,    8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd4, C_MRD,    8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b1, 3'd4, C_MRD,    8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd5, C_WB_LD,  8'd3));
        // store, zero-wait
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd4));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0, 3'd2, C_NONE,   8'd4));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0, 3'd3, C_EX_MEM, 8'd4));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b1, 3'd4, C_ST_RDY, 8'd4));
        // jump with one fetch wait, then halt; start ignored, reset leaves HALT
        vecs.push_back(mk(1'b0, 1'b0, 8'hE8, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd5));
        vecs.push_back(mk(1'b0, 1'b0, 8'hE8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd5));
        vecs.push_back(mk(1'b0, 1'b0, 8'hE8, 1'b0, 1'b1, 1'b0, 3'd2, C_JMP,    8'd5));
        vecs.push_back(mk(1'b0, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 3'd2, C_NONE,   8'd6));
        vecs.push_back(mk(1'b0, 1'b1, 8'hF8, 1'b0, 1'b1, 1'b0, 3'd6, C_HALT,   8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 3'd6, C_HALT,   8'd6));
        vecs.push_back(mk(1'b1, 1'b0, 8'hF8, 1'b0, 1'b1, 1'b0, 3'd6, C_HALT,   8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        // fetch timeout: 4 FETCH cycles then FAULT
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, C_FAULT,  8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        // ready on the 4th fetch cycle is accepted; then undefined opcode faults
        vecs.push_back(mk(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd1, C_FWAIT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd2, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        // reset asserted in the middle of a load wait
        vecs.push_back(mk(1'b0, 1'b1, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd2, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd3, C_EX_MEM, 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd4, C_MRD,    8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b1, 3'd4, C_MRD,    8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        // store data-memory timeout: FAULT with no retire
        vecs.push_back(mk(1'b0, 1'b1, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b1, 1'b0, 3'd1, C_FRDY,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd2, C_NONE,   8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd3, C_EX_MEM, 8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd4, C_MWR,    8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd4, C_MWR,    8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd4, C_MWR,    8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd4, C_MWR,    8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 8'hD8, 1'b0, 1'b0, 1'b0, 3'd7, C_FAULT,  8'd0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, C_NONE,   8'd0));

        reset      = 1'b1;
        start      = 1'b0;
        instr      = 8'h00;
        alu_zero   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset      = vecs[i].rst;
            start      = vecs[i].st;
            instr      = vecs[i].ins;
            alu_zero   = vecs[i].az;
            imem_ready = vecs[i].ir;
            dmem_ready = vecs[i].dr;
            #1;
            check("state",   i, {29'd0, state},   {29'd0, vecs[i].exp_state});
            check("ctl",     i, {19'd0, ctl_s},   {19'd0, vecs[i].exp_ctl});
            check("retired", i, {24'd0, retired}, {24'd0, vecs[i].exp_ret});
        end

        // Counter wrap: 256 back-to-back jumps (2 cycles each) from a clean reset.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        start      = 1'b1;
        instr      = 8'hE8;
        imem_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 256; j++) begin
            @(posedge clock);
            @(posedge clock);
            #1;
            if (j == 255) begin
                check("retired_255", j, {24'd0, retired}, 32'd255);
            end else if (j == 256) begin
                check("retired_wrap", j, {24'd0, retired}, 32'd0);
                check("state_after_wrap", j, {29'd0, state}, 32'd1);
            end else begin
                n_checks = n_checks;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
